// File: rtl/tone_pkg.sv
// Shared constants, FSM state type and amplitude clamp for the triangle tone generator.
package tone_pkg;
  localparam logic [15:0] ZERO_POINT = 16'd32768;
  localparam logic [15:0] AMP_MAX    = 16'd32767;

  typedef enum logic {IDLE, RUN} tone_state_t;

  function automatic logic [15:0] clamp_amp(input logic [15:0] a);
    return (a > AMP_MAX) ? AMP_MAX : a;
  endfunction
endpackage

// File: rtl/tone_shaper.sv
// Combinational triangle shaper: folds the phase MSBs into a signed ramp,
// scales by amplitude and re-centres on ZERO_POINT.
module tone_shaper import tone_pkg::*; (
  input  logic [15:0] p,
  input  logic [15:0] amplitude,
  output logic [15:0] duty_cycle
);
  logic signed [18:0] p2;
  logic signed [18:0] t;
  logic signed [16:0] s;
  logic signed [16:0] a;
  logic signed [32:0] prod;
  logic signed [32:0] y;

  assign p2 = signed'({2'b00, p, 1'b0});
  assign a  = signed'({1'b0, amplitude});

  always_comb begin
    t = '0;
    if (p < 16'd16384)      t = p2;
    else if (p < 16'd49152) t = 19'sd65536 - p2;
    else                    t = p2 - 19'sd131072;
    // only the peak p == 16384 exceeds the positive range
    s    = (t > 19'sd32767) ? 17'sd32767 : 17'(t);
    prod = 33'(s) * 33'(a);
    y    = prod >>> 15;
    // y stays within -32767..32766, so a 16-bit wrap-add gives the offset form
    duty_cycle = 16'(y) + ZERO_POINT;
  end
endmodule

// File: rtl/tone_generator.sv
// Triangle-wave sample source: IDLE/RUN FSM, sample divider, phase accumulator
// and registered outputs. Define TONE_GEN_BURST_EN for burst_len / burst_done.
module tone_generator import tone_pkg::*; #(
  parameter int SAMPLE_DIV = 1024,
  parameter int PHASE_W    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [15:0]        amplitude,
`ifdef TONE_GEN_BURST_EN
  input  logic [7:0]         burst_len,
  output logic               burst_done,
`endif
  output logic               busy,
  output logic [15:0]        duty_cycle,
  output logic               duty_cycle_vld,
  output logic               cycle_done
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  tone_state_t        state;
  logic [DIV_W-1:0]   div;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc_q;
  logic [15:0]        amp_q;
  logic [PHASE_W:0]   phase_sum;
  logic [15:0]        shaped;
  logic               tc;
  logic               burst_hit;

  assign tc        = (div == DIV_W'(SAMPLE_DIV - 1));
  assign phase_sum = {1'b0, phase} + {1'b0, inc_q};
  assign busy      = (state == RUN);

  tone_shaper u_shaper (
    .p          (phase[PHASE_W-1 -: 16]),
    .amplitude  (amp_q),
    .duty_cycle (shaped)
  );

`ifdef TONE_GEN_BURST_EN
  logic [7:0] burst_len_q;
  logic [7:0] periods;
  assign burst_hit = (burst_len_q != 8'd0) && (periods == burst_len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_len_q <= '0;
      periods     <= '0;
      burst_done  <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      if (state == IDLE) begin
        if (start && !stop) begin
          burst_len_q <= burst_len;
          periods     <= '0;
        end
      end else if (stop) begin
        periods <= '0;
      end else if (burst_hit) begin
        burst_done <= 1'b1;
      end else if (tc) begin
        periods <= periods + 8'(phase_sum[PHASE_W]);
      end
    end
  end
`else
  assign burst_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      div            <= '0;
      phase          <= '0;
      inc_q          <= '0;
      amp_q          <= '0;
      duty_cycle     <= ZERO_POINT;
      duty_cycle_vld <= 1'b0;
      cycle_done     <= 1'b0;
    end else begin
      duty_cycle_vld <= 1'b0;
      cycle_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            inc_q <= phase_inc;
            amp_q <= clamp_amp(amplitude);
            phase <= '0;
            div   <= '0;
          end
        end
        RUN: begin
          // stop beats a same-cycle strobe; burst end follows the final strobe
          if (stop || burst_hit) begin
            state      <= IDLE;
            div        <= '0;
            duty_cycle <= ZERO_POINT;
          end else begin
            div <= tc ? '0 : div + 1'b1;
            if (tc) begin
              duty_cycle     <= shaped;
              duty_cycle_vld <= 1'b1;
              phase          <= phase_sum[PHASE_W-1:0];
              cycle_done     <= phase_sum[PHASE_W];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator (SAMPLE_DIV=4, PHASE_W=16): per-cycle
// comparison against a sample-level model plus directed literal expectations.
module tb_tone_generator;
  localparam int SD = 4;
  localparam int PW = 16;

  logic        clk, rst_n, start, stop;
  logic [15:0] phase_inc, amplitude;
  logic [7:0]  burst_len;
  logic        busy, duty_cycle_vld, cycle_done, burst_done;
  logic [15:0] duty_cycle;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int got_q[$];
  int t_q[$];
  int cd_q[$];
  int bd_cyc = -1;

  tone_generator #(.SAMPLE_DIV(SD), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .phase_inc(phase_inc), .amplitude(amplitude),
`ifdef TONE_GEN_BURST_EN
    .burst_len(burst_len), .burst_done(burst_done),
`endif
    .busy(busy), .duty_cycle(duty_cycle),
    .duty_cycle_vld(duty_cycle_vld), .cycle_done(cycle_done)
  );

`ifndef TONE_GEN_BURST_EN
  assign burst_done = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int tri_sample(input longint p, input longint amp);
    longint s, prod, y;
    if (p < 16384)      s = 2 * p;
    else if (p < 49152) s = 65536 - 2 * p;
    else                s = 2 * p - 131072;
    if (s > 32767) s = 32767;
    prod = s * amp;
    y = (prod >= 0) ? prod / 32768 : -((-prod + 32767) / 32768);
    return int'(y + 32768);
  endfunction

  bit     m_run = 0, m_vld = 0, m_cd = 0, m_bd = 0;
  int     m_duty = 32768;
  longint m_cnt = 0, m_k = 0, m_inc = 0, m_amp = 0, m_bl = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_vld = 0; m_cd = 0; m_bd = 0; m_duty = 32768;
    end else begin
      m_vld = 0; m_cd = 0; m_bd = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_run = 1; m_cnt = 0; m_k = 0;
          m_inc = phase_inc;
          m_amp = (amplitude > 32767) ? 32767 : amplitude;
`ifdef TONE_GEN_BURST_EN
          m_bl = burst_len;
`else
          m_bl = 0;
`endif
        end
      end else if (stop) begin
        m_run = 0; m_duty = 32768;
      end else if (m_bl != 0 && ((m_k * m_inc) >> PW) >= m_bl) begin
        m_run = 0; m_duty = 32768; m_bd = 1;
      end else begin
        m_cnt++;
        if (m_cnt % SD == 0) begin
          m_duty = tri_sample((m_k * m_inc) % 65536, m_amp);
          m_vld  = 1;
          m_cd   = (((m_k + 1) * m_inc) >> PW) != ((m_k * m_inc) >> PW);
          m_k++;
        end
      end
    end
  end

  // compare + monitor, at the falling edge
  initial forever begin
    @(negedge clk);
    cyc++;
    chk("cmp_busy", 32'(busy), 32'(m_run));
    chk("cmp_duty", 32'(duty_cycle), 32'(m_duty));
    chk("cmp_vld",  32'(duty_cycle_vld), 32'(m_vld));
    chk("cmp_cycle_done", 32'(cycle_done), 32'(m_cd));
    chk("cmp_burst_done", 32'(burst_done), 32'(m_bd));
    if (duty_cycle_vld === 1'b1) begin
      got_q.push_back(int'(duty_cycle));
      t_q.push_back(cyc);
      cd_q.push_back(int'(cycle_done));
    end
    if (burst_done === 1'b1) bd_cyc = cyc;
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(negedge clk); #1;
  endtask

  task automatic clear_q;
    got_q.delete(); t_q.delete(); cd_q.delete();
  endtask

  task automatic pulse_start(input logic [15:0] inc, input logic [15:0] amp);
    phase_inc = inc; amplitude = amp; start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_vld(input int n);
    int b = 0;
    while (got_q.size() < n && b < 200) begin tick; b++; end
    if (got_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_vld: got %0d samples expected %0d", got_q.size(), n);
    end
  endtask

  task automatic stop_now(input string name);
    int n;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    n = got_q.size();
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_duty"}, 32'(duty_cycle), 32'd32768);
    chk({name, "_vld"},  32'(duty_cycle_vld), 32'd0);
    repeat (3 * SD) tick;
    chk({name, "_no_more_vld"}, 32'(got_q.size()), 32'(n));
  endtask

  int pat1[4] = '{32768, 65534, 32768, 1};
  int pat3[5] = '{32768, 40960, 49151, 40960, 32768};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    phase_inc = '0; amplitude = '0; burst_len = '0;
    repeat (3) tick;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_duty", 32'(duty_cycle), 32'd32768);
    chk("rst_vld",  32'(duty_cycle_vld), 32'd0);
    chk("rst_cycle_done", 32'(cycle_done), 32'd0);
    rst_n = 1'b1;
    tick;

    // start together with stop in IDLE does nothing
    start = 1'b1; stop = 1'b1; phase_inc = 16'h4000; amplitude = 16'd100;
    tick;
    start = 1'b0; stop = 1'b0;
    tick;
    chk("idle_start_stop_busy", 32'(busy), 32'd0);

    // full-scale quarter-step triangle
    clear_q;
    pulse_start(16'h4000, 16'd32767);
    wait_vld(8);
    chk("first_vld_latency", 32'(t_q[0] - (cyc - 8 * SD) + 1), 32'(SD + 1));
    for (int i = 0; i < 8; i++) begin
      chk("tri_sample", 32'(got_q[i]), 32'(pat1[i % 4]));
      chk("tri_cycle_done", 32'(cd_q[i]), 32'(i % 4 == 3));
      if (i > 0) chk("vld_spacing", 32'(t_q[i] - t_q[i-1]), 32'(SD));
    end
    // start during RUN is ignored
    phase_inc = 16'h1000; amplitude = 16'd0; start = 1'b1;
    tick;
    start = 1'b0;
    wait_vld(12);
    for (int i = 8; i < 12; i++) chk("run_start_ignored", 32'(got_q[i]), 32'(pat1[i % 4]));
    // stop between strobes
    wait_vld(13);
    stop_now("stop_off_strobe");

    // zero amplitude, then stop on a strobe edge
    clear_q;
    pulse_start(16'h1234, 16'd0);
    wait_vld(6);
    for (int i = 0; i < 6; i++) chk("amp0_sample", 32'(got_q[i]), 32'd32768);
    repeat (SD - 1) tick;
    stop_now("stop_on_strobe");

    // eighth-step, half amplitude
    clear_q;
    pulse_start(16'h2000, 16'd16384);
    wait_vld(5);
    for (int i = 0; i < 5; i++) chk("half_amp_sample", 32'(got_q[i]), 32'(pat3[i]));
    stop_now("stop_half");

    // over-range amplitude clamps; async reset mid-RUN
    clear_q;
    pulse_start(16'h4000, 16'hFFFF);
    wait_vld(2);
    chk("amp_clamp", 32'(got_q[1]), 32'd65534);
    tick;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_duty", 32'(duty_cycle), 32'd32768);
    chk("async_rst_vld",  32'(duty_cycle_vld), 32'd0);
    chk("async_rst_cd",   32'(cycle_done), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    clear_q;
    pulse_start(16'h4000, 16'd32767);
    wait_vld(2);
    chk("restart_first", 32'(got_q[0]), 32'd32768);
    chk("restart_second", 32'(got_q[1]), 32'd65534);
    stop_now("stop_restart");

`ifdef TONE_GEN_BURST_EN
    clear_q;
    burst_len = 8'd2;
    pulse_start(16'h4000, 16'd32767);
    begin
      int b = 0;
      while (busy && b < 100) begin tick; b++; end
    end
    chk("burst_busy_low", 32'(busy), 32'd0);
    repeat (2 * SD) tick;
    chk("burst_vld_count", 32'(got_q.size()), 32'd8);
    if (got_q.size() == 8) chk("burst_done_cycle", 32'(bd_cyc), 32'(t_q[7] + 1));
    burst_len = 8'd0;
`endif

    repeat (2) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
